// File: rtl/sender_pkg.sv
// Shared types and ASCII constants for the time report sender.
// Pure definitions: no logic, no latency, no flow control.
package sender_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Full frame "HH:MM:SS.CC\r\n"; the CR LF tail is optional at the top level.
    localparam int FRAME_LEN = 13;
    localparam int IDX_W     = 4;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/bin2ascii2.sv
// Binary byte to two ASCII decimal digits, saturating values above 99 to "99".
// Purely combinational; no latency, no backpressure.
module bin2ascii2
    import sender_pkg::*;
(
    input  logic [7:0] bin,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    logic [6:0] val;

    always_comb begin
        val  = (bin > 8'd99) ? 7'd99 : bin[6:0];
        tens = ASCII_ZERO + {1'b0, val / 7'd10};
        ones = ASCII_ZERO + {1'b0, val % 7'd10};
    end

endmodule

// File: rtl/time_ascii_sender.sv
// Sends a latched time snapshot as "HH:MM:SS.CC[\r\n]"; first byte 1 clk after send.
// Valid/ready output: a byte is held stable until tx_ready takes it; send ignored while busy.
module time_ascii_sender
    import sender_pkg::*;
#(
    parameter int APPEND_CRLF = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [31:0] sender_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = (APPEND_CRLF != 0) ? IDX_W'(FRAME_LEN - 1)
                                                               : IDX_W'(FRAME_LEN - 3);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [31:0]      snap, snap_nxt;
    logic             done_nxt;
    logic             xfer;
    logic             last_xfer;
    logic [7:0]       tens [4];
    logic [7:0]       ones [4];

    // Field 0 is the hour in the top byte, field 3 the centiseconds.
    for (genvar g = 0; g < 4; g++) begin : g_field
        bin2ascii2 u_cvt (
            .bin  (snap[31-8*g -: 8]),
            .tens (tens[g]),
            .ones (ones[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            snap       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            snap       <= snap_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        snap_nxt  = snap;
        done_nxt  = 1'b0;
        xfer      = (state == SEND) && tx_ready;
        last_xfer = xfer && (idx == LAST_IDX);
        case (state)
            IDLE: begin
                if (send) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                    snap_nxt  = sender_data;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    done_nxt = 1'b1;
                    idx_nxt  = '0;
                    // A request landing on the final transfer chains straight into a new frame.
                    if (send) snap_nxt  = sender_data;
                    else      state_nxt = IDLE;
                end else if (xfer) begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        if (state == SEND) begin
            case (idx)
                4'd0:    tx_data = tens[0];
                4'd1:    tx_data = ones[0];
                4'd2:    tx_data = ASCII_COLON;
                4'd3:    tx_data = tens[1];
                4'd4:    tx_data = ones[1];
                4'd5:    tx_data = ASCII_COLON;
                4'd6:    tx_data = tens[2];
                4'd7:    tx_data = ones[2];
                4'd8:    tx_data = ASCII_DOT;
                4'd9:    tx_data = tens[3];
                4'd10:   tx_data = ones[3];
                4'd11:   tx_data = ASCII_CR;
                4'd12:   tx_data = ASCII_LF;
                default: tx_data = 8'h00;
            endcase
        end
    end

    assign tx_valid = (state == SEND);
    assign busy     = (state == SEND);

endmodule

// File: tb/tb_time_ascii_sender.sv
// Bench for time_ascii_sender: randomized frames checked against a string-level frame model.
module tb_time_ascii_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        send;
    logic [31:0] sender_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned exp_q[$];
    byte unsigned rx_q[$];
    int           stab_err;
    int           done_cnt;
    int           gap_cnt;
    bit           busy_dropped;
    bit           start_ok;
    bit           timed_out;

    always #5 clk = ~clk;

    time_ascii_sender #(.APPEND_CRLF(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .send        (send),
        .sender_data (sender_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // Reference frame: each field rendered in decimal (clamped to 99), joined by ":", ":", "." and CR LF.
    task automatic add_frame(input logic [31:0] d);
        int f;
        int v;
        for (int i = 0; i < 4; i++) begin
            f = int'(d[31-8*i -: 8]);
            v = (f > 99) ? 99 : f;
            exp_q.push_back(8'(48 + v / 10));
            exp_q.push_back(8'(48 + v % 10));
            if (i < 2)       exp_q.push_back(8'h3A);
            else if (i == 2) exp_q.push_back(8'h2E);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    function automatic int first_diff();
        int n;
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (rx_q[i] !== exp_q[i]) return i;
        if (rx_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Drives one send and acts as the UART sink until `frames` frame_done pulses are seen.
    task automatic run_frames(input logic [31:0] d, input int stall, input int frames,
                              input int again_at, input logic [31:0] again_d, input bit scramble);
        int          stall_cnt;
        int          in_frame;
        int          cyc;
        bit          prev_stall;
        byte unsigned prev_dat;
        rx_q.delete();
        stab_err = 0; done_cnt = 0; gap_cnt = 0; busy_dropped = 0; timed_out = 0;
        @(negedge clk);
        sender_data = d;
        send        = 1'b1;
        tx_ready    = (stall == 0);
        @(negedge clk);
        send       = 1'b0;
        start_ok   = (tx_valid === 1'b1);
        stall_cnt  = stall;
        prev_stall = 1'b0;
        prev_dat   = 8'h00;
        in_frame   = 0;
        cyc        = 0;
        forever begin
            if (frame_done === 1'b1) begin
                done_cnt++;
                in_frame = 0;
                if (done_cnt == frames) break;
            end
            if (busy !== 1'b1) busy_dropped = 1'b1;
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_dat)) stab_err++;
            if (scramble) sender_data = $urandom;
            send = 1'b0;
            if (tx_valid === 1'b1) begin
                if (stall_cnt > 0) begin
                    tx_ready   = 1'b0;
                    stall_cnt--;
                    prev_stall = 1'b1;
                    prev_dat   = tx_data;
                end else begin
                    tx_ready   = 1'b1;
                    prev_stall = 1'b0;
                    rx_q.push_back(tx_data);
                    stall_cnt  = stall;
                    if (done_cnt == 0 && in_frame == again_at) begin
                        send        = 1'b1;
                        sender_data = again_d;
                    end
                    in_frame++;
                end
            end else begin
                tx_ready   = 1'b0;
                prev_stall = 1'b0;
                gap_cnt++;
            end
            cyc++;
            if (cyc > 2000) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
        end
        send     = 1'b0;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; send = 1'b1; tx_ready = 1'b1; sender_data = $urandom;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        rst = 1'b0; send = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_send_priority: busy %b want 0", busy); end
    endtask

    task automatic test_basic();
        int d;
        exp_q.delete();
        add_frame(32'h0C22_0763);
        run_frames(32'h0C22_0763, 0, 1, -1, 32'h0, 1'b0);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
        n_checks++; if (!start_ok) begin n_fail++; $display("FAIL basic_start_latency: tx_valid not 1 one clk after send"); end
        d = first_diff();
        n_checks++; if (d !== -1) begin n_fail++; $display("FAIL basic_frame: first difference at byte %0d, got %0d bytes want %0d", d, rx_q.size(), exp_q.size()); end
        n_checks++; if (gap_cnt !== 0) begin n_fail++; $display("FAIL basic_back_to_back_bytes: %0d idle cycles want 0", gap_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle: got %b want 0", frame_done); end
    endtask

    task automatic test_saturate();
        int d;
        exp_q.delete();
        add_frame(32'hFF3B_0064);
        run_frames(32'hFF3B_0064, 0, 1, -1, 32'h0, 1'b0);
        d = first_diff();
        n_checks++; if (timed_out || d !== -1) begin n_fail++; $display("FAIL saturate_frame: diff at %0d, got %0d bytes want %0d", d, rx_q.size(), exp_q.size()); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        int          st;
        int          d;
        for (int k = 0; k < 6; k++) begin
            r  = $urandom;
            st = $urandom_range(0, 2);
            exp_q.delete();
            add_frame(r);
            run_frames(r, st, 1, -1, 32'h0, 1'b0);
            d = first_diff();
            n_checks++; if (timed_out || d !== -1) begin n_fail++; $display("FAIL random_frame: data %h stall %0d diff at %0d, got %0d bytes want %0d", r, st, d, rx_q.size(), exp_q.size()); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        int          d;
        r = $urandom;
        exp_q.delete();
        add_frame(r);
        run_frames(r, 3, 1, -1, 32'h0, 1'b0);
        d = first_diff();
        n_checks++; if (timed_out || d !== -1) begin n_fail++; $display("FAIL stall_frame: diff at %0d, got %0d bytes want %0d", d, rx_q.size(), exp_q.size()); end
        n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL stall_stability: %0d unstable cycles want 0", stab_err); end
    endtask

    task automatic test_ignore_send();
        logic [31:0] r;
        int          d;
        r = $urandom;
        exp_q.delete();
        add_frame(r);
        run_frames(r, 0, 1, 5, ~r, 1'b1);
        d = first_diff();
        n_checks++; if (timed_out || d !== -1) begin n_fail++; $display("FAIL ignore_send_frame: diff at %0d, got %0d bytes want %0d", d, rx_q.size(), exp_q.size()); end
        repeat (3) @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ignore_send_not_queued: tx_valid %b busy %b want 0 0", tx_valid, busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1;
        logic [31:0] r2;
        int          d;
        r1 = $urandom;
        r2 = $urandom;
        exp_q.delete();
        add_frame(r1);
        add_frame(r2);
        run_frames(r1, 0, 2, 12, r2, 1'b0);
        d = first_diff();
        n_checks++; if (timed_out || d !== -1) begin n_fail++; $display("FAIL b2b_frames: diff at %0d, got %0d bytes want %0d", d, rx_q.size(), exp_q.size()); end
        n_checks++; if (busy_dropped) begin n_fail++; $display("FAIL b2b_busy: busy dropped between frames, want held high"); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] r1;
        logic [31:0] r2;
        int          d;
        r1 = $urandom;
        r2 = $urandom;
        exp_q.delete();
        add_frame(r1);
        @(negedge clk);
        sender_data = r1; send = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[6]) begin n_fail++; $display("FAIL mid_reset_byte6: got %b/%h want 1/%h", tx_valid, tx_data, exp_q[6]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_abort: tx_valid %b busy %b want 0 0", tx_valid, busy); end
        repeat (2) @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_quiet: tx_valid %b frame_done %b want 0 0", tx_valid, frame_done); end
        tx_ready = 1'b0;
        exp_q.delete();
        add_frame(r2);
        run_frames(r2, 0, 1, -1, 32'h0, 1'b0);
        d = first_diff();
        n_checks++; if (timed_out || d !== -1) begin n_fail++; $display("FAIL mid_reset_fresh_frame: diff at %0d, got %0d bytes want %0d", d, rx_q.size(), exp_q.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; send = 1'b0; tx_ready = 1'b0; sender_data = 32'h0;
        test_reset();
        test_basic();
        test_saturate();
        test_random();
        test_backpressure();
        test_ignore_send();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_ascii_sender.md
TIME_ASCII_SENDER -- requirements
Module: time_ascii_sender

Interface
REQ-001 SHALL have parameter APPEND_CRLF, default 1, meaning 1 appends CR LF (13-byte frame) and 0 omits them (11-byte frame).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port send  input  1  single-cycle request to transmit one time report.
REQ-005 SHALL have port sender_data  input  32  packed binary time: [31:24] hour, [23:16] min, [15:8] sec, [7:0] centisec.
REQ-006 SHALL have port tx_data  output  8  ASCII byte offered to the UART transmitter.
REQ-007 SHALL have port tx_valid  output  1  tx_data is valid; held until accepted.
REQ-008 SHALL have port tx_ready  input  1  UART transmitter can accept a byte this cycle.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-011 SHALL emit the frame "HH:MM:SS.CC" in order, followed by 0x0D 0x0A when APPEND_CRLF=1.
REQ-012 SHALL convert each field to two ASCII digits: tens = v/10 + 0x30, ones = v%10 + 0x30.
REQ-013 SHALL saturate any field value >99 to "99".
REQ-014 SHALL latch sender_data into an internal snapshot on the cycle send is sampled high in IDLE; later sender_data changes SHALL NOT alter the frame in progress.
REQ-015 SHALL use the FSM states IDLE and SEND: IDLE->SEND on send; SEND->IDLE when the last byte transfers.
REQ-016 SHALL assert tx_valid with byte 0 on the cycle after send is sampled; start latency SHALL be 1 clk.
REQ-017 SHALL count a byte as transferred only on a clock edge with tx_valid=1 and tx_ready=1, and SHALL then advance the byte index.
REQ-018 SHALL keep tx_data and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-019 SHALL present the next byte on the cycle after a transfer, giving back-to-back bytes when tx_ready stays high (13 bytes in 13 clk).
REQ-020 SHALL drive busy high in SEND and low in IDLE.
REQ-021 SHALL pulse frame_done for exactly one cycle, coincident with the SEND->IDLE transition.
REQ-022 SHALL ignore send while busy=1; such a request SHALL NOT be queued.
REQ-023 SHALL accept a send arriving in the same cycle as the last transfer: the FSM SHALL stay in SEND with a new snapshot and byte index 0, frame_done SHALL still pulse, and busy SHALL stay high.
REQ-024 SHALL drive the byte index range 0..FRAME_LEN-1 and SHALL reset the index to 0 at frame end, with no wrap beyond FRAME_LEN.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, force state IDLE, byte index 0, snapshot 0, tx_valid 0, tx_data 0x00, busy 0, frame_done 0.
REQ-026 SHALL abort a frame in progress when reset is applied mid-frame, with no further bytes offered.
REQ-027 SHALL give rst priority over send in the same cycle.

Structure
REQ-028 SHALL take the state enum, the ASCII constants (0x30, ':', '.', CR, LF) and FRAME_LEN from a shared package named sender_pkg.
REQ-029 SHALL instantiate sub-module bin2ascii2 (8-bit binary to two ASCII digits with saturation) once per field, combinationally on the snapshot.
REQ-030 SHALL select the outgoing byte with a mux indexed by the byte index; no other storage is permitted.

Verification
REQ-031 Hold tx_ready=1; pulse send with sender_data=0x0C_22_07_63 -> bytes "12:34:07.99" 0D 0A on 13 consecutive cycles, then frame_done pulse, then busy=0.
REQ-032 Use sender_data=0xFF_3B_00_64 -> frame "99:59:00.99\r\n".
REQ-033 Apply tx_ready backpressure, toggling low 3 clk between each byte -> tx_data/tx_valid stable while stalled, with no byte lost or duplicated.
REQ-034 Pulse send again at byte 5, and change sender_data mid-frame -> a single frame is sent, matching the original snapshot.
REQ-035 Pulse send on the last-transfer cycle -> a second full frame follows immediately, with busy never dropping.
REQ-036 Assert rst at byte 6, then release -> tx_valid=0 the next cycle; a following send produces a complete fresh frame from byte 0.
